ex2_wb_sched: RTL and testbench
===============================

EX2_WB_SCHED -- requirements
Module: ex2_wb_sched

Interface
REQ-001 SHALL have ports, one per line, name direction width meaning:
- clk  in  1  sole clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (exception/interrupt)
- issue_valid  in  1  dual-lane group offered from EX1
- issue_kind0 / issue_kind1  in  2  lane op class: 0 ALU, 1 DIV, 2 LOAD, 3 CSR
- issue_rd0 / issue_rd1  in  5  destination register
- issue_data0 / issue_data1  in  32  ALU result (ignored for non-ALU kind)
- issue_ready  out  1  group accepted this cycle when issue_valid && issue_ready
- div_ready, dcache_ready, csr_ready  in  1  unit response pulses
- div_data, dcache_data, csr_data  in  32  unit response data
- wb_we0 / wb_we1  out  1  regfile write enable per lane
- wb_rd0 / wb_rd1  out  5  write register
- wb_data0 / wb_data1  out  32  write data
- busy  out  1  FSM in WAIT
- timeout  out  1  one-cycle pulse on watchdog expiry
REQ-002 SHALL use parameter TIMEOUT_MAX, default 255, meaning: WAIT cycles before the watchdog aborts.

Function
REQ-003 SHALL implement FSM states IDLE and WAIT; issue_ready = (state==IDLE).
REQ-004 In IDLE, an accepted all-ALU group SHALL produce wb outputs on the next cycle: latency 1, in-order, both lanes together.
REQ-005 An accepted group with one non-ALU lane SHALL capture both lanes' rd, kind and ALU data and enter WAIT.
REQ-006 At most one non-ALU lane per group is an issue-side precondition; if both lanes are non-ALU, lane1 SHALL be treated as ALU with data 0.
REQ-007 In WAIT, only the ready pulse matching the captured kind SHALL complete the group; unrelated ready pulses are ignored.
REQ-008 Unit ready pulses in the acceptance cycle SHALL be ignored; units guarantee latency of at least 1.
REQ-009 On completion, the next cycle SHALL drive both lanes: the unit data on the waiting lane and captured ALU data on the other; the FSM SHALL return to IDLE.
REQ-010 wb_weN SHALL be 1 only in the single write cycle and only when wb_rdN != 0; when wb_weN=0, wb_rdN and wb_dataN SHALL be 0.
REQ-011 flush SHALL win over all simultaneous events: an IDLE group with flush is not accepted; WAIT with flush goes to IDLE with no write; a response coinciding with flush is discarded.
REQ-012 An 8-bit watchdog SHALL clear on WAIT entry and increment each WAIT cycle; reaching TIMEOUT_MAX SHALL pulse timeout, return to IDLE and discard the group.
REQ-013 A completion in the same cycle as watchdog expiry SHALL complete normally, without a timeout pulse.
REQ-014 busy SHALL equal (state==WAIT).

Reset
REQ-015 aresetn low SHALL immediately force IDLE, clear the watchdog, and zero all wb_* outputs and timeout; issue_ready SHALL be 1 and busy 0.
REQ-016 Reset asserted mid-WAIT SHALL abandon the group with no write after deassertion.

Structure
REQ-017 Kind encodings (ALU/DIV/LOAD/CSR) and state encoding SHALL reside in the shared define package.
REQ-018 The watchdog SHALL be a sub-module, wb_timeout_cnt (clear, enable, expire).

Verification
REQ-019 ALU group rd0=3/data 0x11, rd1=0/data 0x22 -> next cycle we0=1, rd0=3, data0=0x11; we1=0.
REQ-020 Lane0 DIV rd=5, lane1 ALU rd=6/0x7; div_ready after 10 cycles with 0x2A -> next cycle writes r5=0x2A and r6=0x7; issue_ready low during WAIT.
REQ-021 Lane1 LOAD rd=9; csr_ready pulse, then dcache_ready with 0xDEAD -> only the dcache response completes the group, r9=0xDEAD.
REQ-022 Lane0 CSR in WAIT; flush together with csr_ready -> no write, IDLE next cycle.
REQ-023 Lane0 DIV with no response -> timeout pulse after 255 WAIT cycles, no write, issue_ready returns to 1.
REQ-024 aresetn low during WAIT, then a late dcache_ready -> no write, FSM IDLE.

Source files
------------

// File: rtl/ex2_wb_sched_pkg.sv
// Shared definitions for the EX2 writeback scheduler: op kinds, FSM states, group records.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ex2_wb_sched_pkg;

  localparam int XLEN   = 32;
  localparam int REGW   = 5;
  localparam int WDOG_W = 8;

  // Lane operation class as presented by EX1
  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_DIV  = 2'd1,
    KIND_LOAD = 2'd2,
    KIND_CSR  = 2'd3
  } kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Group parked while one lane waits on a multi-cycle unit
  typedef struct packed {
    logic             wait_lane;  // 0: lane0 waits, 1: lane1 waits
    kind_e            kind;       // unit whose response completes the group
    logic [REGW-1:0]  rd0;
    logic [REGW-1:0]  rd1;
    logic [XLEN-1:0]  alu_data;   // result for the lane that is not waiting
  } grp_t;

  // One regfile write port
  typedef struct packed {
    logic             we;
    logic [REGW-1:0]  rd;
    logic [XLEN-1:0]  data;
  } wr_t;

  // Writes to r0 are suppressed, and an idle port carries all-zero rd/data
  function automatic wr_t mk_wr(input logic [REGW-1:0] rd, input logic [XLEN-1:0] data);
    wr_t w;
    w.we   = (rd != '0);
    w.rd   = w.we ? rd : '0;
    w.data = w.we ? data : '0;
    return w;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Watchdog for the WAIT state: counts cycles while enabled, flags the final one.
// Latency: expire is combinational from the count during the MAX-th enabled cycle.
// Backpressure: none; clear has priority over enable, count saturates.
module wb_timeout_cnt
  import ex2_wb_sched_pkg::*;
#(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(MAX - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // Next count: clear on WAIT entry, otherwise step once per enabled cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count holds N-1 during the N-th enabled cycle
  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/ex2_wb_sched.sv
// EX2 writeback scheduler: retires dual-lane groups, parking on one slow unit (DIV/LOAD/CSR).
// Latency: 1 cycle for all-ALU groups; 1 cycle after the matching unit response otherwise.
// Backpressure: issue_ready drops for the whole WAIT; flush or watchdog expiry abandons a group.
module ex2_wb_sched
  import ex2_wb_sched_pkg::*;
#(
  parameter int TIMEOUT_MAX = 255
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic [1:0]      issue_kind0,
  input  logic [1:0]      issue_kind1,
  input  logic [4:0]      issue_rd0,
  input  logic [4:0]      issue_rd1,
  input  logic [31:0]     issue_data0,
  input  logic [31:0]     issue_data1,
  output logic            issue_ready,
  input  logic            div_ready,
  input  logic            dcache_ready,
  input  logic            csr_ready,
  input  logic [31:0]     div_data,
  input  logic [31:0]     dcache_data,
  input  logic [31:0]     csr_data,
  output logic            wb_we0,
  output logic            wb_we1,
  output logic [4:0]      wb_rd0,
  output logic [4:0]      wb_rd1,
  output logic [31:0]     wb_data0,
  output logic [31:0]     wb_data1,
  output logic            busy,
  output logic            timeout
);

  state_e          state_q, state_d;
  grp_t            grp_q, grp_d;
  wr_t             wr0_q, wr0_d, wr1_q, wr1_d;
  logic            timeout_q, timeout_d;

  kind_e           k0, k1;
  logic            accept;
  logic            lane0_slow, lane1_slow;
  logic            resp_hit;
  logic [XLEN-1:0] resp_data;
  logic            wd_clear, wd_en, wd_expire;

  assign k0         = kind_e'(issue_kind0);
  assign k1         = kind_e'(issue_kind1);
  assign lane0_slow = (k0 != KIND_ALU);
  assign lane1_slow = (k1 != KIND_ALU);
  // flush blocks acceptance even though ready is still advertised
  assign accept     = issue_valid && (state_q == ST_IDLE) && !flush;

  assign wd_clear   = accept && (lane0_slow || lane1_slow);
  assign wd_en      = (state_q == ST_WAIT);

  wb_timeout_cnt #(
    .MAX (TIMEOUT_MAX)
  ) u_wdog (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expire  (wd_expire)
  );

  // Pick the response of the unit the parked group is waiting on; others are ignored
  always_comb begin
    resp_hit  = 1'b0;
    resp_data = '0;
    case (grp_q.kind)
      KIND_DIV:  begin resp_hit = div_ready;    resp_data = div_data;    end
      KIND_LOAD: begin resp_hit = dcache_ready; resp_data = dcache_data; end
      KIND_CSR:  begin resp_hit = csr_ready;    resp_data = csr_data;    end
      default:   begin resp_hit = 1'b0;         resp_data = '0;          end
    endcase
  end

  // Next state, group capture and registered writeback/timeout decisions
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    wr0_d     = '0;
    wr1_d     = '0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (lane0_slow) begin
            // A second slow lane is illegal; it degrades to an ALU write of 0
            grp_d.wait_lane = 1'b0;
            grp_d.kind      = k0;
            grp_d.rd0       = issue_rd0;
            grp_d.rd1       = issue_rd1;
            grp_d.alu_data  = lane1_slow ? '0 : issue_data1;
            state_d         = ST_WAIT;
          end else if (lane1_slow) begin
            grp_d.wait_lane = 1'b1;
            grp_d.kind      = k1;
            grp_d.rd0       = issue_rd0;
            grp_d.rd1       = issue_rd1;
            grp_d.alu_data  = issue_data0;
            state_d         = ST_WAIT;
          end else begin
            wr0_d = mk_wr(issue_rd0, issue_data0);
            wr1_d = mk_wr(issue_rd1, issue_data1);
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (resp_hit) begin
          // Completion beats a coincident watchdog expiry
          state_d = ST_IDLE;
          wr0_d   = mk_wr(grp_q.rd0, grp_q.wait_lane ? grp_q.alu_data : resp_data);
          wr1_d   = mk_wr(grp_q.rd1, grp_q.wait_lane ? resp_data : grp_q.alu_data);
        end else if (wd_expire) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, parked group and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      grp_q     <= '0;
      wr0_q     <= '0;
      wr1_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      wr0_q     <= wr0_d;
      wr1_q     <= wr1_d;
      timeout_q <= timeout_d;
    end
  end

  assign issue_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_WAIT);
  assign timeout     = timeout_q;
  assign wb_we0      = wr0_q.we;
  assign wb_rd0      = wr0_q.rd;
  assign wb_data0    = wr0_q.data;
  assign wb_we1      = wr1_q.we;
  assign wb_rd1      = wr1_q.rd;
  assign wb_data1    = wr1_q.data;

endmodule

// File: tb/tb_ex2_wb_sched.sv
// Directed bench for ex2_wb_sched with a write/timeout scoreboard.
// Latency: stimulus pushes expected writes; a negedge monitor pops on every wb pulse.
// Backpressure: WAIT-state ready/busy behaviour is checked inline by the stimulus.
module tb_ex2_wb_sched;
  import ex2_wb_sched_pkg::*;

  logic        clk, aresetn, flush, issue_valid, issue_ready;
  logic [1:0]  issue_kind0, issue_kind1;
  logic [4:0]  issue_rd0, issue_rd1;
  logic [31:0] issue_data0, issue_data1;
  logic        div_ready, dcache_ready, csr_ready;
  logic [31:0] div_data, dcache_data, csr_data;
  logic        wb_we0, wb_we1, busy, timeout;
  logic [4:0]  wb_rd0, wb_rd1;
  logic [31:0] wb_data0, wb_data1;

  typedef struct {
    logic        we0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        we1;
    logic [4:0]  rd1;
    logic [31:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int   to_exp;
  int   n_cmp;
  int   n_fail;

  ex2_wb_sched #(.TIMEOUT_MAX(255)) dut (
    .clk(clk), .aresetn(aresetn), .flush(flush),
    .issue_valid(issue_valid), .issue_kind0(issue_kind0), .issue_kind1(issue_kind1),
    .issue_rd0(issue_rd0), .issue_rd1(issue_rd1),
    .issue_data0(issue_data0), .issue_data1(issue_data1), .issue_ready(issue_ready),
    .div_ready(div_ready), .dcache_ready(dcache_ready), .csr_ready(csr_ready),
    .div_data(div_data), .dcache_data(dcache_data), .csr_data(csr_data),
    .wb_we0(wb_we0), .wb_we1(wb_we1), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .busy(busy), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [1:0] k0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic [1:0] k1, input logic [4:0] r1, input logic [31:0] d1);
    issue_valid = 1'b1;
    issue_kind0 = k0; issue_rd0 = r0; issue_data0 = d0;
    issue_kind1 = k1; issue_rd1 = r1; issue_data1 = d1;
    tick();
    issue_valid = 1'b0;
    issue_kind0 = '0; issue_rd0 = '0; issue_data0 = '0;
    issue_kind1 = '0; issue_rd1 = '0; issue_data1 = '0;
  endtask

  // which: 1 DIV, 2 LOAD, 3 CSR
  task automatic pulse(input int which, input logic [31:0] d);
    div_ready    = (which == 1); div_data    = d;
    dcache_ready = (which == 2); dcache_data = d;
    csr_ready    = (which == 3); csr_data    = d;
    tick();
    div_ready = 1'b0; dcache_ready = 1'b0; csr_ready = 1'b0;
    div_data = '0; dcache_data = '0; csr_data = '0;
  endtask

  task automatic expect_wr(input logic we0, input logic [4:0] rd0, input logic [31:0] d0,
                           input logic we1, input logic [4:0] rd1, input logic [31:0] d1);
    exp_t e;
    e.we0 = we0; e.rd0 = rd0; e.d0 = d0;
    e.we1 = we1; e.rd1 = rd1; e.d1 = d1;
    exp_q.push_back(e);
  endtask

  // Monitor: every write pulse must match the oldest expected group; idle ports stay zero
  always @(negedge clk) begin
    if (aresetn) begin
      if (wb_we0 || wb_we1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got we0=%0b rd0=%0d d0=0x%0h we1=%0b rd1=%0d d1=0x%0h, expected no write",
                   wb_we0, wb_rd0, wb_data0, wb_we1, wb_rd1, wb_data1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_we0",   {31'd0, wb_we0}, {31'd0, e.we0});
          chk("wb_rd0",   {27'd0, wb_rd0}, {27'd0, e.rd0});
          chk("wb_data0", wb_data0,        e.d0);
          chk("wb_we1",   {31'd0, wb_we1}, {31'd0, e.we1});
          chk("wb_rd1",   {27'd0, wb_rd1}, {27'd0, e.rd1});
          chk("wb_data1", wb_data1,        e.d1);
        end
      end
      if (!wb_we0) chk("idle_port0", {wb_rd0, wb_data0[26:0]} | {5'd0, wb_data0[31:27], 22'd0}, 32'd0);
      if (!wb_we1) chk("idle_port1", {wb_rd1, wb_data1[26:0]} | {5'd0, wb_data1[31:27], 22'd0}, 32'd0);
      if (timeout) begin
        if (to_exp == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_timeout: got timeout=1, expected 0");
        end else begin
          n_cmp++;
          to_exp--;
        end
      end
    end
  end

  initial begin
    exp_q.delete();
    to_exp = 0; n_cmp = 0; n_fail = 0;
    aresetn = 1'b0; flush = 1'b0; issue_valid = 1'b0;
    issue_kind0 = '0; issue_kind1 = '0; issue_rd0 = '0; issue_rd1 = '0;
    issue_data0 = '0; issue_data1 = '0;
    div_ready = 1'b0; dcache_ready = 1'b0; csr_ready = 1'b0;
    div_data = '0; dcache_data = '0; csr_data = '0;

    // Reset state
    #2;
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_busy",        {31'd0, busy},        32'd0);
    chk("rst_timeout",     {31'd0, timeout},     32'd0);
    chk("rst_we",          {30'd0, wb_we0, wb_we1}, 32'd0);
    ticks(2);
    aresetn = 1'b1;
    tick();

    // ALU group, rd1 = 0 suppresses lane1
    expect_wr(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    issue(KIND_ALU, 5'd3, 32'h11, KIND_ALU, 5'd0, 32'h22);
    tick();

    // ALU group, both lanes written
    expect_wr(1'b1, 5'd1, 32'hAAAA, 1'b1, 5'd31, 32'h5555);
    issue(KIND_ALU, 5'd1, 32'hAAAA, KIND_ALU, 5'd31, 32'h5555);
    tick();

    // Lane0 DIV, response after 10 cycles
    issue(KIND_DIV, 5'd5, 32'hFFFF, KIND_ALU, 5'd6, 32'h7);
    chk("div_busy",        {31'd0, busy},        32'd1);
    chk("div_issue_ready", {31'd0, issue_ready}, 32'd0);
    ticks(9);
    chk("div_still_wait",  {31'd0, issue_ready}, 32'd0);
    expect_wr(1'b1, 5'd5, 32'h2A, 1'b1, 5'd6, 32'h7);
    pulse(1, 32'h2A);
    chk("div_done_ready",  {31'd0, issue_ready}, 32'd1);
    chk("div_done_busy",   {31'd0, busy},        32'd0);

    // Lane1 LOAD; unrelated CSR/DIV pulses must not complete it
    issue(KIND_ALU, 5'd8, 32'h123, KIND_LOAD, 5'd9, 32'h0);
    tick();
    pulse(3, 32'hBAD);
    pulse(1, 32'hBAD1);
    chk("load_ignores_other", {31'd0, busy}, 32'd1);
    expect_wr(1'b1, 5'd8, 32'h123, 1'b1, 5'd9, 32'hDEAD);
    pulse(2, 32'hDEAD);

    // Response in the acceptance cycle is ignored
    dcache_ready = 1'b1; dcache_data = 32'hBEEF;
    issue(KIND_LOAD, 5'd4, 32'h0, KIND_ALU, 5'd10, 32'h55);
    dcache_ready = 1'b0; dcache_data = '0;
    chk("accept_cycle_resp_ignored", {31'd0, busy}, 32'd1);
    tick();
    expect_wr(1'b1, 5'd4, 32'h1234, 1'b1, 5'd10, 32'h55);
    pulse(2, 32'h1234);

    // Flush together with the CSR response: no write, back to IDLE
    issue(KIND_CSR, 5'd7, 32'h0, KIND_ALU, 5'd2, 32'h3);
    ticks(2);
    flush = 1'b1;
    pulse(3, 32'hC5);
    flush = 1'b0;
    chk("flush_wait_ready", {31'd0, issue_ready}, 32'd1);
    chk("flush_wait_busy",  {31'd0, busy},        32'd0);
    tick();

    // Flush in IDLE blocks acceptance of an ALU group
    flush = 1'b1;
    issue(KIND_ALU, 5'd20, 32'h99, KIND_ALU, 5'd21, 32'h98);
    flush = 1'b0;
    chk("flush_idle_ready", {31'd0, issue_ready}, 32'd1);
    tick();

    // Both lanes slow: lane1 degrades to ALU with data 0
    issue(KIND_DIV, 5'd11, 32'h1, KIND_CSR, 5'd12, 32'h999);
    tick();
    pulse(3, 32'h3333);
    chk("dual_slow_csr_ignored", {31'd0, busy}, 32'd1);
    expect_wr(1'b1, 5'd11, 32'h77, 1'b1, 5'd12, 32'h0);
    pulse(1, 32'h77);

    // Waiting lane targets r0: only the ALU lane writes
    issue(KIND_ALU, 5'd13, 32'h44, KIND_DIV, 5'd0, 32'h0);
    tick();
    expect_wr(1'b1, 5'd13, 32'h44, 1'b0, 5'd0, 32'h0);
    pulse(1, 32'h99);

    // Watchdog: DIV never answers, pulse after 255 WAIT cycles
    issue(KIND_DIV, 5'd5, 32'h0, KIND_ALU, 5'd6, 32'h1);
    ticks(254);
    chk("wd_busy_254",    {31'd0, busy},    32'd1);
    chk("wd_no_pulse_254", {31'd0, timeout}, 32'd0);
    to_exp++;
    tick();
    chk("wd_pulse",       {31'd0, timeout},     32'd1);
    chk("wd_ready",       {31'd0, issue_ready}, 32'd1);
    tick();
    chk("wd_pulse_once",  {31'd0, timeout},     32'd0);

    // Response in the expiry cycle completes normally
    issue(KIND_LOAD, 5'd14, 32'h0, KIND_ALU, 5'd15, 32'h66);
    ticks(254);
    expect_wr(1'b1, 5'd14, 32'hCAFE, 1'b1, 5'd15, 32'h66);
    pulse(2, 32'hCAFE);
    chk("expiry_complete_no_to", {31'd0, timeout}, 32'd0);
    chk("expiry_complete_idle",  {31'd0, busy},    32'd0);
    tick();

    // Reset mid-WAIT abandons the group; a late response writes nothing
    issue(KIND_ALU, 5'd1, 32'h1, KIND_LOAD, 5'd9, 32'h0);
    ticks(3);
    aresetn = 1'b0;
    #1;
    chk("rst_wait_busy",  {31'd0, busy},        32'd0);
    chk("rst_wait_ready", {31'd0, issue_ready}, 32'd1);
    ticks(2);
    aresetn = 1'b1;
    tick();
    pulse(2, 32'hD00D);
    chk("rst_late_resp_idle", {31'd0, busy}, 32'd0);
    ticks(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("timeouts_drained",   to_exp,       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
